json_motor_cmd_tx: RTL and testbench
====================================

# json_motor_cmd_tx

Parametrised successor to the fixed-string JSON command sender. It accepts signed left/right wheel speeds over a valid/ready handshake, converts them to ASCII decimal, and serialises a variable-length frame `{"T":<t>,"L":<l>,"R":<r>}` over an integrated 8N1-style UART transmitter. It sits between the FFT/motor control logic and the motor controller's serial input. Callers supply speed words, not pre-built strings.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200).
- `BITS_N`, default 8: UART data bits per character, sent LSB first. Legal range 7..8.
- `SPEED_W`, default 8: width of the signed speed inputs. Legal range 2..16.
- `CMD_T`, default 1: command type value. Legal range 0..9, sent as one ASCII digit.

- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-low reset (`rst`=0 resets on the next `clk` edge).
- `cmd_valid`, in, 1: a command is offered.
- `cmd_ready`, out, 1: block can accept a command.
- `speed_l`, in, `SPEED_W`: signed two's-complement left speed.
- `speed_r`, in, `SPEED_W`: signed two's-complement right speed.
- `uart_out`, out, 1: serial line, idle high.
- `busy`, out, 1: a frame is being converted or sent.
- `done`, out, 1: one-cycle pulse when a frame completes.
- `current_byte`, out, 8: character currently on the line. Debug only.

## Operation
- States and transitions:
  - IDLE → CONV on handshake (`cmd_valid && cmd_ready`).
  - CONV → SEND after conversion of both channels.
  - SEND → DONE after the last stop bit.
  - DONE → IDLE after 1 cycle.
- Handshake and input capture:
  - `cmd_ready` = 1 only in IDLE with `rst`=1.
  - `speed_l` and `speed_r` are captured on the handshake cycle. Later input changes are ignored.
- CONV:
  - Take the magnitude of each channel, then run a double-dabble BCD conversion.
  - L is converted in `SPEED_W` cycles, then R in `SPEED_W` cycles.
  - The magnitude of the most-negative value (e.g. -128 for `SPEED_W`=8) is handled exactly, with width extended by 1 bit.
- Number formatting:
  - '-' prefix only if the value is negative. Zero is sent as "0".
  - No leading zeros and no '+' sign.
- Frame contents:
  - Fixed text is 17 characters plus the L digits/sign plus the R digits/sign (plus the newline when enabled).
  - Character sequence: `{` `"` `T` `"` `:` CMD_T `,` `"` `L` `"` `:` L `,` `"` `R` `"` `:` R `}`.
- UART character format:
  - 1 start bit (0), then `BITS_N` data bits LSB first, then 1 stop bit (1), each bit `CLKS_PER_BIT` cycles.
  - Characters go back to back with no idle gap.
  - With `BITS_N`=7, bit 7 of each character is dropped.
- `current_byte` holds the character being transmitted in SEND and 0x00 otherwise.
- `busy` = 1 in CONV, SEND and DONE.
- `done` = 1 only in DONE.
- Reset mid-operation:
  - The frame is abandoned.
  - `uart_out` = 1 from the next edge on, and the block returns to IDLE.
  - No `done` pulse is issued.
- A `cmd_valid` asserted while busy is held off via `cmd_ready`=0. It is never dropped or queued.

## Timing
- Reset values: `uart_out`=1, `cmd_ready`=0, `busy`=0, `done`=0, `current_byte`=0x00.
- After reset release, `cmd_ready`=1 on the first cycle.
- Handshake at edge N: `busy`=1 and `cmd_ready`=0 after edge N.
- Start bit of the first character drives `uart_out` low after edge N+2·`SPEED_W`+2.
- Frame length: (frame chars)·(`BITS_N`+2)·`CLKS_PER_BIT` cycles.
- `done`=1 for exactly the cycle following the end of the last stop bit. `cmd_ready`=1 on the cycle after that.
- Earliest back-to-back: the next handshake is possible 2 cycles after the final stop bit ends.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `JSON_CMD_NEWLINE_EN`:
  - Defined: a 0x0A character is appended after `}`, making the frame 1 character longer. `done` follows its stop bit.
  - Undefined: the frame ends at `}`.

## Test plan
- Reset held 5 cycles, then released → `uart_out`=1 and `cmd_ready`=1 on the first cycle after release. No line activity for 1000 cycles without `cmd_valid`.
- L=100, R=-45, `SPEED_W`=8, `CMD_T`=1 → decoded line reads `{"T":1,"L":100,"R":-45}` (23 chars). First start bit after edge N+18. `done` pulses once.
- L=0, R=-128 → `{"T":1,"L":0,"R":-128}`. Timing checks:
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - No idle gaps between characters.
- `cmd_valid` held high with changing speeds during a frame → the second command is accepted only after `done`. The first frame is unchanged, and the second frame carries the values present on the second handshake.
- `rst`=0 during the 5th character → `uart_out`=1 next cycle, no `done`. A fresh command afterwards produces a complete, correct frame.
- With `JSON_CMD_NEWLINE_EN` defined, L=5, R=5 → `{"T":1,"L":5,"R":5}` followed by 0x0A. `done` comes after the newline's stop bit.

Source files
------------

// File: rtl/json_motor_cmd_tx.sv
// json_motor_cmd_tx
//
// Accepts a pair of signed wheel speeds over a valid/ready handshake,
// converts each to ASCII decimal with a double-dabble BCD converter and
// transmits the frame {"T":<t>,"L":<l>,"R":<r>} over a built-in UART
// transmitter (1 start bit, BITS_N data bits LSB first, 1 stop bit).
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit
//   BITS_N       : data bits per character (7..8)
//   SPEED_W      : width of the signed speed inputs (2..16)
//   CMD_T        : command type digit (0..9)
//
// Ports
//   clk          : clock
//   rst          : synchronous reset, active low
//   cmd_valid    : command offered
//   cmd_ready    : block can accept a command (registered)
//   speed_l      : signed left speed, captured on the handshake
//   speed_r      : signed right speed, captured on the handshake
//   uart_out     : serial line, idle high
//   busy         : frame being converted or sent
//   done         : one-cycle pulse after the last stop bit
//   current_byte : character on the line while sending, 0x00 otherwise
//
// Build option
//   JSON_CMD_NEWLINE_EN : when defined, a 0x0A character follows '}'.

module json_motor_cmd_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int SPEED_W      = 8,
    parameter int CMD_T        = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [SPEED_W-1:0] speed_l,
    input  logic signed [SPEED_W-1:0] speed_r,
    output logic                      uart_out,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                current_byte
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BCD_W = 20;                 // five BCD digits cover |-32768|
    localparam int DD_W  = BCD_W + SPEED_W;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       STOP_IDX  = 4'(BITS_N + 1);
    localparam logic [3:0]       LAST_DATA = 4'(BITS_N);
    localparam logic [5:0]       L_END     = 6'(SPEED_W - 1);
    localparam logic [5:0]       R_END     = 6'(2 * SPEED_W - 1);
    localparam logic [5:0]       LEN_AT    = 6'(2 * SPEED_W);
    localparam logic [5:0]       CONV_LAST = 6'(2 * SPEED_W + 1);
    localparam logic [7:0]       CMD_CHAR  = 8'(8'h30 + CMD_T);

`ifdef JSON_CMD_NEWLINE_EN
    localparam logic [5:0] FIXED_LAST = 6'd17;
`else
    localparam logic [5:0] FIXED_LAST = 6'd16;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_SEND,
        S_DONE
    } state_t;

    state_t state, state_n;

    // Control registers
    logic [5:0]       conv_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;     // 0 = start, 1..BITS_N = data, BITS_N+1 = stop
    logic [5:0]       char_idx;

    // Datapath registers (not reset: always loaded before use)
    logic signed [SPEED_W-1:0] spd_r;
    logic                      neg_l, neg_r;
    logic [DD_W-1:0]           dd;
    logic [BCD_W-1:0]          bcd_l, bcd_r;
    logic [2:0]                nd_l, nd_r;
    logic [3:0]                len_l, len_r;
    logic [5:0]                frame_last;

    logic [DD_W-1:0] dd_next;
    logic [2:0]      nd_l_c, nd_r_c;
    logic [3:0]      len_l_c, len_r_c;
    logic [5:0]      char_sel;
    logic [7:0]      next_char;
    logic            hs;
    logic            frame_end;

    // Magnitude in SPEED_W+1 bits so the most-negative input negates exactly;
    // the result always fits back into SPEED_W unsigned bits.
    function automatic logic [SPEED_W-1:0] mag_of(input logic signed [SPEED_W-1:0] s);
        logic signed [SPEED_W:0] e;
        e = {s[SPEED_W-1], s};
        if (e < 0) begin
            e = -e;
        end
        return e[SPEED_W-1:0];
    endfunction

    // One double-dabble iteration on {bcd, binary}: add 3 to digits >= 5, shift left.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] t;
        t = v;
        for (int k = 0; k < BCD_W / 4; k++) begin
            if (t[SPEED_W + 4*k +: 4] >= 4'd5) begin
                t[SPEED_W + 4*k +: 4] = t[SPEED_W + 4*k +: 4] + 4'd3;
            end
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

    // Significant decimal digits; zero still prints as a single "0".
    function automatic logic [2:0] digit_count(input logic [BCD_W-1:0] bcd);
        logic [2:0] n;
        n = 3'd1;
        for (int k = 1; k < BCD_W / 4; k++) begin
            if (bcd[4*k +: 4] != 4'd0) begin
                n = 3'(k + 1);
            end
        end
        return n;
    endfunction

    // Character p of a number field: optional '-' then digits, most significant first.
    function automatic logic [7:0] field_char(input int p, input logic [2:0] nd,
                                              input logic neg, input logic [BCD_W-1:0] bcd);
        int k;
        logic [7:0] c;
        if (neg && (p == 0)) begin
            c = 8'h2D;
        end else begin
            k = int'(nd) - 1 - (p - int'(neg));
            if (k < 0) begin
                k = 0;
            end
            c = {4'h3, bcd[4*k +: 4]};
        end
        return c;
    endfunction

    assign dd_next = dd_step(dd);
    assign nd_l_c  = digit_count(bcd_l);
    assign nd_r_c  = digit_count(bcd_r);
    assign len_l_c = {1'b0, nd_l_c} + {3'b000, neg_l};
    assign len_r_c = {1'b0, nd_r_c} + {3'b000, neg_r};

    assign hs        = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign frame_end = (bit_cnt == BIT_LAST) && (bit_idx == STOP_IDX) &&
                       (char_idx == frame_last);
    assign char_sel  = (state == S_SEND) ? (char_idx + 6'd1) : 6'd0;

    // Frame character generator, indexed by position in the frame
    always_comb begin
        int i;
        int j;
        next_char = 8'h00;
        i = int'(char_sel);
        j = i - 11 - int'(len_l);
        if (i <= 10) begin
            case (i)
                0:       next_char = 8'h7B;   // {
                1:       next_char = 8'h22;   // "
                2:       next_char = 8'h54;   // T
                3:       next_char = 8'h22;
                4:       next_char = 8'h3A;   // :
                5:       next_char = CMD_CHAR;
                6:       next_char = 8'h2C;   // ,
                7:       next_char = 8'h22;
                8:       next_char = 8'h4C;   // L
                9:       next_char = 8'h22;
                default: next_char = 8'h3A;
            endcase
        end else if (j < 0) begin
            next_char = field_char(i - 11, nd_l, neg_l, bcd_l);
        end else if (j < 5) begin
            case (j)
                0:       next_char = 8'h2C;
                1:       next_char = 8'h22;
                2:       next_char = 8'h52;   // R
                3:       next_char = 8'h22;
                default: next_char = 8'h3A;
            endcase
        end else if (j < 5 + int'(len_r)) begin
            next_char = field_char(j - 5, nd_r, neg_r, bcd_r);
        end else if (j == 5 + int'(len_r)) begin
            next_char = 8'h7D;                // }
        end else begin
            next_char = 8'h0A;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (hs)                      state_n = S_CONV;
            S_CONV: if (conv_cnt == CONV_LAST)   state_n = S_SEND;
            S_SEND: if (frame_end)               state_n = S_DONE;
            S_DONE:                              state_n = S_IDLE;
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            uart_out     <= 1'b1;
            current_byte <= 8'h00;
            conv_cnt     <= 6'd0;
            bit_cnt      <= '0;
            bit_idx      <= 4'd0;
            char_idx     <= 6'd0;
        end else begin
            state     <= state_n;
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            case (state)
                S_CONV: begin
                    conv_cnt <= conv_cnt + 6'd1;
                    if (state_n == S_SEND) begin
                        uart_out     <= 1'b0;
                        current_byte <= next_char;
                        bit_cnt      <= '0;
                        bit_idx      <= 4'd0;
                        char_idx     <= 6'd0;
                    end
                end
                S_SEND: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == STOP_IDX) begin
                            if (char_idx == frame_last) begin
                                uart_out     <= 1'b1;
                                current_byte <= 8'h00;
                            end else begin
                                // Next start bit follows the stop bit with no gap
                                char_idx     <= char_idx + 6'd1;
                                current_byte <= next_char;
                                uart_out     <= 1'b0;
                                bit_idx      <= 4'd0;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 4'd1;
                            uart_out <= (bit_idx == LAST_DATA) ? 1'b1
                                                               : current_byte[bit_idx[2:0]];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    conv_cnt     <= 6'd0;
                    uart_out     <= 1'b1;
                    current_byte <= 8'h00;
                end
            endcase
        end
    end

    // Capture and BCD conversion: L during counts 0..W-1, R during W..2W-1,
    // field lengths latched at 2W, one spare cycle before the first start bit.
    always_ff @(posedge clk) begin
        if (hs) begin
            spd_r <= speed_r;
            neg_l <= speed_l[SPEED_W-1];
            neg_r <= speed_r[SPEED_W-1];
            dd    <= {{BCD_W{1'b0}}, mag_of(speed_l)};
        end else if (state == S_CONV) begin
            if (conv_cnt == L_END) begin
                bcd_l <= dd_next[DD_W-1 -: BCD_W];
                dd    <= {{BCD_W{1'b0}}, mag_of(spd_r)};
            end else if (conv_cnt == R_END) begin
                bcd_r <= dd_next[DD_W-1 -: BCD_W];
                dd    <= dd_next;
            end else if (conv_cnt == LEN_AT) begin
                nd_l       <= nd_l_c;
                nd_r       <= nd_r_c;
                len_l      <= len_l_c;
                len_r      <= len_r_c;
                frame_last <= FIXED_LAST + {2'b00, len_l_c} + {2'b00, len_r_c};
            end else if (conv_cnt < R_END) begin
                dd <= dd_next;
            end
        end
    end

endmodule

// File: tb/tb_json_motor_cmd_tx.sv
module tb_json_motor_cmd_tx;

    localparam int CPB = 4;
    localparam int BN  = 8;
    localparam int W   = 8;
    localparam int CT  = 1;

    logic                clk;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic signed [W-1:0] speed_l;
    logic signed [W-1:0] speed_r;
    logic                uart_out;
    logic                busy;
    logic                done;
    logic [7:0]          current_byte;

    json_motor_cmd_tx #(
        .CLKS_PER_BIT(CPB),
        .BITS_N      (BN),
        .SPEED_W     (W),
        .CMD_T       (CT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .speed_l     (speed_l),
        .speed_r     (speed_r),
        .uart_out    (uart_out),
        .busy        (busy),
        .done        (done),
        .current_byte(current_byte)
    );

    int         errors   = 0;
    int         checks   = 0;
    int         cyc      = 0;
    int         prev_end = 0;
    int         last_len = 0;
    int         done_cyc = 0;
    bit         mon_en   = 1'b1;
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected frame text built independently with $sformatf
    function automatic void push_frame(input int l, input int r);
        string s;
        s = $sformatf("{\"T\":%0d,\"L\":%0d,\"R\":%0d}", CT, l, r);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        last_len = s.len();
`ifdef JSON_CMD_NEWLINE_EN
        exp_q.push_back(8'h0A);
        last_len = last_len + 1;
`endif
    endfunction

    // UART receiver: samples every cycle of every bit at the falling edge
    task automatic rx_char();
        logic [7:0] ch;
        logic [7:0] e;
        logic       ok;
        int         st;
        st = cyc;
        ok = 1'b1;
        if (mon_en && exp_q.size() != 0 && exp_q[0] != 8'h7B)
            check("char_gap", st - prev_end, 1);
        for (int i = 1; i < CPB; i++) begin
            @(negedge clk);
            if (uart_out !== 1'b0) ok = 1'b0;
        end
        ch = 8'h00;
        for (int b = 0; b < BN; b++) begin
            @(negedge clk);
            ch[b] = uart_out;
            for (int i = 1; i < CPB; i++) begin
                @(negedge clk);
                if (uart_out !== ch[b]) ok = 1'b0;
            end
        end
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            if (uart_out !== 1'b1) ok = 1'b0;
        end
        prev_end = cyc;
        if (mon_en) begin
            check("bit_timing", ok, 1);
            check("char_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("char", ch, e);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (uart_out === 1'b0) rx_char();
        end
    end

    task automatic do_handshake(input int l, input int r, input bit keep, output int hs);
        int n;
        speed_l   = W'(l);
        speed_r   = W'(r);
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("handshake_wait", cmd_ready, 1);
        push_frame(l, r);
        @(negedge clk);
        hs = cyc;
        check("busy_after_hs", busy, 1);
        check("ready_after_hs", cmd_ready, 0);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_frame(input int hs, input bit wiggle, input int fl, input int fr);
        int n;
        int rdy;
        n   = 0;
        rdy = 0;
        while (uart_out !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
            if (cmd_ready === 1'b1) rdy++;
        end
        check("first_start_cyc", cyc - hs, 2 * W + 2);
        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
            if (cmd_ready === 1'b1) rdy++;
            if (wiggle && (n % 37 == 0)) begin
                speed_l = W'($urandom);
                speed_r = W'($urandom);
            end
        end
        done_cyc = cyc;
        if (wiggle) begin
            speed_l = W'(fl);
            speed_r = W'(fr);
        end
        check("done_cyc", cyc - hs, 2 * W + 2 + last_len * (BN + 2) * CPB);
        check("ready_held_off", rdy, 0);
        check("frame_complete", exp_q.size(), 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("ready_after_done", cmd_ready, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic run_frame(input int l, input int r);
        int hs;
        do_handshake(l, r, 1'b0, hs);
        wait_frame(hs, 1'b0, 0, 0);
    endtask

    initial begin
        int hs;
        int hs2;
        int act;
        logic signed [W-1:0] rv;
        int rl;
        int rr;

        rst       = 1'b0;
        cmd_valid = 1'b0;
        speed_l   = '0;
        speed_r   = '0;

        // Reset held for 5 cycles
        repeat (5) @(negedge clk);
        check("rst_uart_out", uart_out, 1);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_current_byte", current_byte, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", cmd_ready, 1);
        check("idle_uart_out", uart_out, 1);

        // Quiet line with no command
        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if (uart_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) act++;
        end
        check("idle_quiet", act, 0);

        run_frame(100, -45);
        run_frame(0, -128);
        run_frame(127, -1);
        run_frame(-128, 127);
        for (int k = 0; k < 2; k++) begin
            rv = W'($urandom);
            rl = int'(rv);
            rv = W'($urandom);
            rr = int'(rv);
            run_frame(rl, rr);
        end

        // cmd_valid held with changing speeds; second command waits for done
        do_handshake(7, -3, 1'b1, hs);
        wait_frame(hs, 1'b1, 55, -99);
        do_handshake(55, -99, 1'b0, hs2);
        check("b2b_hs_after_done", hs2 - done_cyc, 2);
        wait_frame(hs2, 1'b0, 0, 0);

        // Reset during the 5th character
        do_handshake(12, -34, 1'b0, hs);
        while (cyc < hs + 2 * W + 2 + 4 * (BN + 2) * CPB + 2) @(negedge clk);
        check("byte_before_abort", current_byte, 8'h3A);
        mon_en = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check("abort_uart_out", uart_out, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_current_byte", current_byte, 0);
        check("abort_ready", cmd_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_release", cmd_ready, 1);
        act = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_out !== 1'b1 || done !== 1'b0 || busy !== 1'b0) act++;
        end
        check("abort_quiet", act, 0);
        exp_q.delete();
        mon_en = 1'b1;
        run_frame(42, -7);

        run_frame(5, 5);

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
